// File: rtl/color_matrix_conv.sv
// color_matrix_conv: 3x3 colour-space matrix with per-row offset, round-half-up
// and saturation. The datapath reads only the active coefficient bank. The
// shadow bank is copied into the active bank on the first ce-qualified vsync
// rising edge after a configuration write.
module color_matrix_conv #(
    parameter int DW   = 8,
    parameter int CW   = 18,
    parameter int FRAC = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic [DW-1:0] in_c0,
    input  logic [DW-1:0] in_c1,
    input  logic [DW-1:0] in_c2,
    input  logic          in_hsync,
    input  logic          in_vsync,
    input  logic          in_de,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic [DW-1:0] out_c0,
    output logic [DW-1:0] out_c1,
    output logic [DW-1:0] out_c2,
    output logic          out_hsync,
    output logic          out_vsync,
    output logic          out_de,
    output logic          cfg_pending
);

    localparam int PW = CW + DW + 1;
    localparam int AW = CW + DW + 3;
    localparam logic signed [AW-1:0] RND  = AW'(1) <<< (FRAC - 1);
    localparam logic signed [AW-1:0] MAXV = AW'((1 << DW) - 1);

    // Convert a coefficient given in units of 1e-4 to Q(CW-FRAC).FRAC,
    // rounding to nearest with ties away from zero.
    function automatic logic signed [CW-1:0] q_coef(input int e4);
        longint mag;
        longint r;
        mag = (e4 < 0) ? -longint'(e4) : longint'(e4);
        r   = (mag * (longint'(1) << FRAC) + longint'(5000)) / longint'(10000);
        return (e4 < 0) ? CW'(-r) : CW'(r);
    endfunction

    // BT.601 full-range RGB->YCbCr, row-major
    function automatic logic signed [CW-1:0] def_coef(input int idx);
        case (idx)
            0:       return q_coef(2990);
            1:       return q_coef(5870);
            2:       return q_coef(1140);
            3:       return q_coef(-1687);
            4:       return q_coef(-3313);
            5:       return q_coef(5000);
            6:       return q_coef(5000);
            7:       return q_coef(-4187);
            8:       return q_coef(-813);
            default: return '0;
        endcase
    endfunction

    // Luma row has no offset; chroma rows sit at mid-scale
    function automatic logic signed [DW:0] def_off(input int idx);
        logic signed [DW:0] v;
        v = '0;
        if (idx != 0) v[DW-1] = 1'b1;
        return v;
    endfunction

    logic signed [CW-1:0] sh_m   [9];
    logic signed [CW-1:0] act_m  [9];
    logic signed [DW:0]   sh_off [3];
    logic signed [DW:0]   act_off[3];
    logic signed [CW-1:0] eff_m  [9];
    logic signed [DW:0]   eff_off[3];

    logic signed [DW:0]   px     [3];
    logic signed [PW-1:0] prod   [9];
    logic signed [DW:0]   off_s1 [3];
    logic signed [AW-1:0] sa     [3];
    logic signed [AW-1:0] sb     [3];
    logic signed [AW-1:0] s3     [3];
    logic signed [AW-1:0] sh_res [3];
    logic [DW-1:0]        sat    [3];

    logic [3:0] hs_d, vs_d, de_d;
    logic       vsync_q;
    logic       wr_ok;
    logic       swap;

    assign wr_ok = cfg_we && (cfg_addr < 4'd12);
    assign swap  = ce && in_vsync && !vsync_q && cfg_pending;

    // Registered vsync for frame-boundary edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  vsync_q <= 1'b0;
        else if (ce) vsync_q <= in_vsync;
    end

    // Shadow bank: written whenever cfg_we targets a valid address, ce or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) sh_m[i]   <= def_coef(i);
            for (int i = 0; i < 3; i++) sh_off[i] <= def_off(i);
        end else if (wr_ok) begin
            for (int i = 0; i < 9; i++)
                if (cfg_addr == 4'(i)) sh_m[i] <= cfg_data;
            for (int i = 0; i < 3; i++)
                if (cfg_addr == 4'(9 + i)) sh_off[i] <= cfg_data[DW:0];
        end
    end

    // Active bank: takes the pre-write shadow contents on a swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) act_m[i]   <= def_coef(i);
            for (int i = 0; i < 3; i++) act_off[i] <= def_off(i);
        end else if (swap) begin
            for (int i = 0; i < 9; i++) act_m[i]   <= sh_m[i];
            for (int i = 0; i < 3; i++) act_off[i] <= sh_off[i];
        end
    end

    // Pending flag: a write wins over a coincident swap so the new data is not lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cfg_pending <= 1'b0;
        else if (wr_ok)  cfg_pending <= 1'b1;
        else if (swap)   cfg_pending <= 1'b0;
    end

    // Pixel sampled on the swap cycle already uses the incoming bank
    always_comb begin
        for (int i = 0; i < 9; i++) eff_m[i]   = swap ? sh_m[i]   : act_m[i];
        for (int i = 0; i < 3; i++) eff_off[i] = swap ? sh_off[i] : act_off[i];
        px[0] = {1'b0, in_c0};
        px[1] = {1'b0, in_c1};
        px[2] = {1'b0, in_c2};
    end

    // S1: nine products; offsets travel with them so in-flight pixels stay consistent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) prod[i]   <= '0;
            for (int i = 0; i < 3; i++) off_s1[i] <= '0;
        end else if (ce) begin
            for (int i = 0; i < 9; i++) prod[i]   <= PW'(eff_m[i]) * PW'(px[i % 3]);
            for (int i = 0; i < 3; i++) off_s1[i] <= eff_off[i];
        end
    end

    // S2: partial sums, offset and rounding constant folded in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                sa[r] <= '0;
                sb[r] <= '0;
            end
        end else if (ce) begin
            for (int r = 0; r < 3; r++) begin
                sa[r] <= AW'(prod[3*r]) + AW'(prod[3*r+1]);
                sb[r] <= AW'(prod[3*r+2]) + (AW'(off_s1[r]) <<< FRAC) + RND;
            end
        end
    end

    // S3: final sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) s3[r] <= '0;
        end else if (ce) begin
            for (int r = 0; r < 3; r++) s3[r] <= sa[r] + sb[r];
        end
    end

    // Arithmetic shift back to integer and clamp to [0, 2^DW-1]
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            sh_res[r] = s3[r] >>> FRAC;
            sat[r]    = '0;
            if (sh_res[r][AW-1])     sat[r] = '0;
            else if (sh_res[r] > MAXV) sat[r] = '1;
            else                     sat[r] = sh_res[r][DW-1:0];
        end
    end

    // S4: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_c0 <= '0;
            out_c1 <= '0;
            out_c2 <= '0;
        end else if (ce) begin
            out_c0 <= sat[0];
            out_c1 <= sat[1];
            out_c2 <= sat[2];
        end
    end

    // Timing signals delayed to match the four pixel stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d <= '0;
            vs_d <= '0;
            de_d <= '0;
        end else if (ce) begin
            hs_d <= {hs_d[2:0], in_hsync};
            vs_d <= {vs_d[2:0], in_vsync};
            de_d <= {de_d[2:0], in_de};
        end
    end

    assign out_hsync = hs_d[3];
    assign out_vsync = vs_d[3];
    assign out_de    = de_d[3];

endmodule

// File: tb/tb_color_matrix_conv.sv
// Testbench for color_matrix_conv: directed pixels with hand-computed results
// queued at issue time, checked by an independent output monitor.
module tb_color_matrix_conv;

    localparam int DW = 8;
    localparam int CW = 18;
    localparam int FRAC = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic [DW-1:0] in_c0 = '0, in_c1 = '0, in_c2 = '0;
    logic          in_hsync = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [CW-1:0] cfg_data = '0;
    logic [DW-1:0] out_c0, out_c1, out_c2;
    logic          out_hsync, out_vsync, out_de, cfg_pending;

    color_matrix_conv #(.DW(DW), .CW(CW), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .in_c0(in_c0), .in_c1(in_c1), .in_c2(in_c2),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
        .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
        logic       h;
        logic       v;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every ce-qualified edge that presents a valid pixel pops one expectation
    always @(posedge clk) begin : mon
        logic ce_s;
        exp_t e;
        ce_s = ce;
        #1;
        if (rst_n && ce_s && out_de === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pixel: got (%0d,%0d,%0d) expected none", out_c0, out_c1, out_c2);
            end else begin
                e = sb_q.pop_front();
                chk("px_c0", out_c0, e.c0);
                chk("px_c1", out_c1, e.c1);
                chk("px_c2", out_c2, e.c2);
                chk("px_hsync", out_hsync, e.h);
                chk("px_vsync", out_vsync, e.v);
            end
        end
    end

    task automatic drive(input logic [7:0] a, b, c, input logic h, v, d, input logic cev,
                         input logic [7:0] e0, e1, e2);
        @(negedge clk);
        in_c0 = a; in_c1 = b; in_c2 = c;
        in_hsync = h; in_vsync = v; in_de = d; ce = cev;
        if (cev && d) sb_q.push_back(exp_t'{e0, e1, e2, h, v});
        @(posedge clk);
    endtask

    task automatic bubble(input logic v, input logic cev);
        drive(8'd0, 8'd0, 8'd0, 1'b0, v, 1'b0, cev, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic flush();
        repeat (6) bubble(1'b0, 1'b1);
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic cfg(input logic [3:0] a, input logic [CW-1:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d; ce = 1'b0; in_de = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] f0, f1, f2;
        logic       fh, fd;
        int         cnt;
        logic       seen;

        // Reset state
        #12;
        chk("rst_c0", out_c0, 0);
        chk("rst_c1", out_c1, 0);
        chk("rst_c2", out_c2, 0);
        chk("rst_de", out_de, 0);
        chk("rst_pending", cfg_pending, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // BT.601 defaults, including saturation cases
        drive(8'd255, 8'd255, 8'd255, 0, 0, 1, 1, 8'd255, 8'd128, 8'd128);
        drive(8'd0,   8'd0,   8'd0,   0, 0, 1, 1, 8'd0,   8'd128, 8'd128);
        drive(8'd255, 8'd0,   8'd0,   0, 0, 1, 1, 8'd76,  8'd85,  8'd255);
        drive(8'd0,   8'd0,   8'd255, 1, 0, 1, 1, 8'd29,  8'd255, 8'd107);
        drive(8'd0,   8'd255, 8'd0,   0, 0, 1, 1, 8'd150, 8'd44,  8'd21);
        flush();

        // Latency counted in ce-qualified cycles with ce toggling
        drive(8'd0, 8'd0, 8'd0, 1, 0, 1, 1, 8'd0, 8'd128, 8'd128);
        cnt  = 1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            logic cv;
            cv = (k % 2 == 1);
            bubble(1'b0, cv);
            if (cv) cnt++;
            #2;
            if (out_de === 1'b1) seen = 1'b1;
        end
        chk("latency_seen", seen, 1);
        chk("latency_ce_cycles", cnt, 4);
        flush();

        // CE stall mid-stream with junk inputs during the stall
        drive(8'd255, 8'd255, 8'd255, 0, 0, 1, 1, 8'd255, 8'd128, 8'd128);
        drive(8'd0,   8'd0,   8'd0,   0, 0, 1, 1, 8'd0,   8'd128, 8'd128);
        drive(8'd255, 8'd0,   8'd0,   0, 0, 1, 1, 8'd76,  8'd85,  8'd255);
        #2;
        f0 = out_c0; f1 = out_c1; f2 = out_c2; fh = out_hsync; fd = out_de;
        for (int k = 0; k < 7; k++)
            drive(8'(k + 1), 8'(k + 2), 8'(k + 3), 1, 1, 1, 0, 8'd0, 8'd0, 8'd0);
        #2;
        chk("stall_c0", out_c0, f0);
        chk("stall_c1", out_c1, f1);
        chk("stall_c2", out_c2, f2);
        chk("stall_hsync", out_hsync, fh);
        chk("stall_de", out_de, fd);
        drive(8'd0,   8'd0,   8'd255, 0, 0, 1, 1, 8'd29,  8'd255, 8'd107);
        drive(8'd0,   8'd255, 8'd0,   0, 0, 1, 1, 8'd150, 8'd44,  8'd21);
        drive(8'd255, 8'd255, 8'd255, 0, 0, 1, 1, 8'd255, 8'd128, 8'd128);
        flush();

        // Frame-boundary swap: row 0 becomes {0.5, 0, 0}
        cfg(4'd0, 18'd65536);
        cfg(4'd1, 18'd0);
        cfg(4'd2, 18'd0);
        chk("pending_after_write", cfg_pending, 1);
        drive(8'd255, 8'd0, 8'd0, 0, 0, 1, 1, 8'd76, 8'd85, 8'd255);
        bubble(1'b1, 1'b1);
        #1;
        chk("pending_after_swap", cfg_pending, 0);
        drive(8'd201, 8'd0, 8'd0, 0, 1, 1, 1, 8'd101, 8'd94, 8'd229);
        bubble(1'b0, 1'b1);
        drive(8'd255, 8'd0, 8'd0, 0, 0, 1, 1, 8'd128, 8'd85, 8'd255);
        flush();

        // Negative clamp with OFF[1] = 0
        cfg(4'd10, 18'd0);
        bubble(1'b0, 1'b1);
        bubble(1'b1, 1'b1);
        #1;
        chk("pending_clamp_swap", cfg_pending, 0);
        drive(8'd0, 8'd255, 8'd0, 0, 1, 1, 1, 8'd0, 8'd0, 8'd21);
        bubble(1'b0, 1'b1);
        flush();

        // Ignored address leaves pending clear
        cfg(4'd13, 18'd7);
        chk("pending_ignored_addr", cfg_pending, 0);

        // Write coincident with swap: active takes pre-write shadow, pending stays set
        cfg(4'd9, 18'd5);
        bubble(1'b0, 1'b1);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'd11; cfg_data = 18'd0;
        in_vsync = 1'b1; in_de = 1'b0; ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
        chk("pending_coincident", cfg_pending, 1);
        drive(8'd0, 8'd0, 8'd0, 0, 1, 1, 1, 8'd5, 8'd0, 8'd128);
        bubble(1'b0, 1'b1);
        flush();

        // Asynchronous reset mid-operation
        drive(8'd255, 8'd255, 8'd255, 0, 0, 1, 1, 8'd133, 8'd0, 8'd128);
        repeat (3) bubble(1'b0, 1'b1);
        cfg(4'd4, 18'd0);
        chk("pre_reset_c0", out_c0, 133);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("async_rst_c0", out_c0, 0);
        chk("async_rst_c2", out_c2, 0);
        chk("async_rst_pending", cfg_pending, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(8'd0, 8'd0, 8'd0, 1, 0, 0, 1, 8'd0, 8'd0, 8'd0);
            #2;
            chk("post_rst_hsync", out_hsync, (k == 3) ? 1 : 0);
        end
        drive(8'd255, 8'd0, 8'd0, 0, 0, 1, 1, 8'd76, 8'd85, 8'd255);
        drive(8'd255, 8'd255, 8'd255, 0, 0, 1, 1, 8'd255, 8'd128, 8'd128);
        flush();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
